// File: rtl/filter_stream_scheduler.sv
// filter_stream_scheduler: grants one coefficient set or one gap-free frame to the filter control unit.
// Define FILTER_SCHED_STATS_EN to add the frame_cnt / abort_cnt statistics outputs.
module filter_stream_scheduler #(
   parameter int unsigned DATA_BIT     = 15,
   parameter int unsigned DATA_IDBIT   = 2,
   parameter int unsigned ROW_WIDTH    = 512,
   parameter int unsigned COL_WIDTH    = 512,
   parameter int unsigned MASK_WIDTH   = 7,
   parameter int unsigned PIX_CNT_BIT  = 18,
   parameter int unsigned DRAIN_CYCLES = ROW_WIDTH * COL_WIDTH / 2 + 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cf_valid,
   input  logic [DATA_BIT-1:0]   cf_data,
   output logic                  cf_ready,
   input  logic                  pix_valid,
   input  logic [DATA_BIT-1:0]   pix_data,
   output logic                  pix_ready,
   input  logic                  err_clr,
   output logic [DATA_IDBIT-1:0] data_id,
   output logic                  data_valid,
   output logic [DATA_BIT-1:0]   data_out,
   output logic                  cf_loaded,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  err_underrun
`ifdef FILTER_SCHED_STATS_EN
   ,
   output logic [15:0]           frame_cnt,
   output logic [7:0]            abort_cnt
`endif
);

   localparam int unsigned CF_WORDS  = MASK_WIDTH * MASK_WIDTH;
   localparam int unsigned FRAME_PIX = ROW_WIDTH * COL_WIDTH;
   localparam int unsigned DRAIN_BIT = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [PIX_CNT_BIT-1:0] CF_LAST    = PIX_CNT_BIT'(CF_WORDS - 1);
   localparam logic [PIX_CNT_BIT-1:0] PIX_LAST   = PIX_CNT_BIT'(FRAME_PIX - 1);
   localparam logic [DRAIN_BIT-1:0]   DRAIN_LAST = DRAIN_BIT'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StLoadCf, StGap, StStream, StDrain} state_t;

   state_t                  r_state;
   logic [PIX_CNT_BIT-1:0]  r_cnt;
   logic [DRAIN_BIT-1:0]    r_drain_cnt;
   logic                    r_frame_ok;
   logic [DATA_IDBIT-1:0]   r_data_id;
   logic                    r_data_valid;
   logic [DATA_BIT-1:0]     r_data_out;
   logic                    r_cf_loaded;
   logic                    r_frame_done;
   logic                    r_err_underrun;

   logic w_underrun;
   logic w_drain_end;

   assign w_underrun  = ((r_state == StLoadCf) && !cf_valid) ||
                        ((r_state == StStream) && !pix_valid);
   assign w_drain_end = (r_state == StDrain) && (r_drain_cnt == DRAIN_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= StIdle;
         r_cnt          <= '0;
         r_drain_cnt    <= '0;
         r_frame_ok     <= 1'b0;
         r_data_id      <= '0;
         r_data_valid   <= 1'b0;
         r_data_out     <= '0;
         r_cf_loaded    <= 1'b0;
         r_frame_done   <= 1'b0;
         r_err_underrun <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         r_frame_done <= w_drain_end && r_frame_ok;
         if (w_underrun) begin
            r_err_underrun <= 1'b1;
         end else if (err_clr) begin
            r_err_underrun <= 1'b0;
         end
         unique case (r_state)
            StIdle: begin
               r_cnt       <= '0;
               r_drain_cnt <= '0;
               r_frame_ok  <= 1'b0;
               // Coefficients win any tie with pixels.
               if (cf_valid) begin
                  r_state <= StLoadCf;
               end else if (pix_valid && r_cf_loaded) begin
                  r_state <= StStream;
               end
            end
            StLoadCf: begin
               if (cf_valid) begin
                  r_data_valid <= 1'b1;
                  r_data_out   <= cf_data;
                  r_data_id    <= DATA_IDBIT'(1);
                  r_cnt        <= r_cnt + PIX_CNT_BIT'(1);
                  if (r_cnt == CF_LAST) begin
                     r_cf_loaded <= 1'b1;
                     r_state     <= StGap;
                  end
               end else begin
                  r_cf_loaded <= 1'b0;
                  r_state     <= StGap;
               end
            end
            StGap: r_state <= StIdle;
            StStream: begin
               if (pix_valid) begin
                  r_data_valid <= 1'b1;
                  r_data_out   <= pix_data;
                  r_data_id    <= '0;
                  r_cnt        <= r_cnt + PIX_CNT_BIT'(1);
                  if (r_cnt == PIX_LAST) begin
                     r_frame_ok <= 1'b1;
                     r_state    <= StDrain;
                  end
               end else begin
                  r_frame_ok <= 1'b0;
                  r_state    <= StDrain;
               end
            end
            StDrain: begin
               if (w_drain_end) begin
                  r_state <= StIdle;
               end else begin
                  r_drain_cnt <= r_drain_cnt + DRAIN_BIT'(1);
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign cf_ready     = (r_state == StLoadCf);
   assign pix_ready    = (r_state == StStream);
   assign busy         = (r_state != StIdle);
   assign data_id      = r_data_id;
   assign data_valid   = r_data_valid;
   assign data_out     = r_data_out;
   assign cf_loaded    = r_cf_loaded;
   assign frame_done   = r_frame_done;
   assign err_underrun = r_err_underrun;

`ifdef FILTER_SCHED_STATS_EN
   logic [15:0] r_frame_cnt;
   logic [7:0]  r_abort_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frame_cnt <= '0;
         r_abort_cnt <= '0;
      end else begin
         if (w_drain_end && r_frame_ok) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         if (w_underrun && (r_abort_cnt != 8'hFF)) begin
            r_abort_cnt <= r_abort_cnt + 8'd1;
         end
      end
   end

   assign frame_cnt = r_frame_cnt;
   assign abort_cnt = r_abort_cnt;
`endif

endmodule
